// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - serial line and byte report bundle of the 8N1 UART receiver
interface uart_byte_rx_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  uart_rx,
    output rx_data,
    output rx_done,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output uart_rx,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 LSB-first UART receiver with mid-bit sampling and stop check
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int BIT_CNT  = CLK_FREQ / BAUD
) (
  input logic             Clk,
  input logic             Reset_n,
  uart_byte_rx_if.master  bus
);
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CNT_W    = $clog2(BIT_CNT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       data_q;
  logic             done_q;
  logic             ferr_q;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             start_edge;

  // Edge needs prev high, so a line parked low can never look like a new start.
  assign start_edge = prev & ~sync2;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      prev    <= 1'b1;
    end else begin
      sync1  <= bus.uart_rx;
      sync2  <= sync1;
      prev   <= sync2;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_edge) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!sync2) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (sync2) begin
              data_q <= shreg;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - directed bench for uart_byte_rx at an 8-clock bit period
module tb_uart_byte_rx;
  localparam int BIT  = 8;
  localparam int HALF = BIT / 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLK_FREQ(50_000_000), .BAUD(9600), .BIT_CNT(BIT)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  logic [7:0] done_q[$];
  int         done_t[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  logic       prev_done = 1'b0;

  always @(negedge Clk) begin
    if (bus.rx_done) begin
      done_q.push_back(bus.rx_data);
      done_t.push_back(cyc);
    end
    if (bus.frame_err) ferr_cnt++;
    if (bus.rx_done && bus.frame_err) both_cnt++;
    if (bus.rx_done && prev_done) long_cnt++;
    prev_done = bus.rx_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    bus.uart_rx = 1'b0;
    repeat (BIT) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = d[i];
      repeat (BIT) @(negedge Clk);
    end
    bus.uart_rx = stop;
    repeat (BIT) @(negedge Clk);
    bus.uart_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0;
    int f0;
    int lat;
    logic saw_busy;
    logic [7:0] keep;

    vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[3] = '{8'hF0, 1'b0, 0, 1, 8'h3C};
    vecs[4] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[6] = '{8'h81, 1'b1, 1, 0, 8'h81};

    bus.uart_rx = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    check("reset_rx_done", 32'(bus.rx_done), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_rx_busy", 32'(bus.rx_busy), 32'h0);
    Reset_n = 1'b1;
    repeat (2 * BIT) @(negedge Clk);

    for (int v = 0; v < 7; v++) begin
      n0 = done_q.size();
      f0 = ferr_cnt;
      send_byte(vecs[v].data, vecs[v].stop);
      repeat (2 * BIT) @(negedge Clk);
      check($sformatf("vec%0d_done_count", v), 32'(done_q.size() - n0), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d_ferr_count", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_rx_data", v), 32'(bus.rx_data), 32'(vecs[v].exp_data));
    end

    // start-edge to rx_done latency
    lat = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        while (!bus.rx_done && lat < 40 * BIT) begin
          @(negedge Clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat < 2 + HALF + 9 * BIT || lat > 2 + HALF + 9 * BIT + 2) begin
      failures++;
      $display("FAIL latency: got %0d negedges expected %0d +/-1", lat, 2 + HALF + 9 * BIT + 1);
    end
    repeat (2 * BIT) @(negedge Clk);
    check("latency_rx_data", 32'(bus.rx_data), 32'h55);

    // back-to-back frames
    n0 = done_q.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (2 * BIT) @(negedge Clk);
    check("b2b_done_count", 32'(done_q.size() - n0), 32'd2);
    if (done_q.size() - n0 == 2) begin
      check("b2b_first", 32'(done_q[n0]), 32'hA5);
      check("b2b_second", 32'(done_q[n0 + 1]), 32'h3C);
      checks++;
      if (done_t[n0 + 1] - done_t[n0] < 10 * BIT - 1 || done_t[n0 + 1] - done_t[n0] > 10 * BIT + 1) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d expected %0d", done_t[n0 + 1] - done_t[n0], 10 * BIT);
      end
    end

    // short glitch rejected in START
    n0 = done_q.size();
    f0 = ferr_cnt;
    keep = 8'h3C;
    saw_busy = 1'b0;
    bus.uart_rx = 1'b0;
    repeat (2) @(negedge Clk);
    bus.uart_rx = 1'b1;
    repeat (3 * BIT) begin
      @(negedge Clk);
      if (bus.rx_busy) saw_busy = 1'b1;
    end
    check("glitch_saw_busy", 32'(saw_busy), 32'h1);
    check("glitch_busy_end", 32'(bus.rx_busy), 32'h0);
    check("glitch_no_done", 32'(done_q.size() - n0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_rx_data", 32'(bus.rx_data), 32'(keep));

    // bad stop bit, then line parked low
    n0 = done_q.size();
    f0 = ferr_cnt;
    send_byte(8'hF0, 1'b0);
    bus.uart_rx = 1'b0;
    saw_busy = 1'b0;
    repeat (4 * BIT) begin
      @(negedge Clk);
      if (bus.rx_busy) saw_busy = 1'b1;
    end
    check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_done", 32'(done_q.size() - n0), 32'd0);
    check("ferr_rx_data", 32'(bus.rx_data), 32'(keep));
    check("held_low_no_start", 32'(saw_busy), 32'h0);
    bus.uart_rx = 1'b1;
    repeat (2 * BIT) @(negedge Clk);
    send_byte(8'h5A, 1'b1);
    repeat (2 * BIT) @(negedge Clk);
    check("after_held_low_data", 32'(bus.rx_data), 32'h5A);

    // reset in the middle of data bit 4
    n0 = done_q.size();
    bus.uart_rx = 1'b0;
    repeat (5 * BIT + HALF) @(negedge Clk);
    Reset_n = 1'b0;
    bus.uart_rx = 1'b1;
    @(negedge Clk);
    check("midreset_rx_data", 32'(bus.rx_data), 32'h00);
    check("midreset_rx_busy", 32'(bus.rx_busy), 32'h0);
    check("midreset_rx_done", 32'(bus.rx_done), 32'h0);
    check("midreset_frame_err", 32'(bus.frame_err), 32'h0);
    Reset_n = 1'b1;
    repeat (2 * BIT) @(negedge Clk);
    send_byte(8'h81, 1'b1);
    repeat (2 * BIT) @(negedge Clk);
    check("post_reset_done_count", 32'(done_q.size() - n0), 32'd1);
    check("post_reset_rx_data", 32'(bus.rx_data), 32'h81);

    // every byte value back-to-back
    n0 = done_q.size();
    f0 = ferr_cnt;
    for (int v = 0; v < 256; v++) send_byte(8'(v), 1'b1);
    repeat (2 * BIT) @(negedge Clk);
    check("sweep_done_count", 32'(done_q.size() - n0), 32'd256);
    check("sweep_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    if (done_q.size() - n0 == 256) begin
      for (int v = 0; v < 256; v++) check($sformatf("sweep_byte_%0d", v), 32'(done_q[n0 + v]), 32'(v));
    end

    check("done_and_ferr_overlap", 32'(both_cnt), 32'd0);
    check("done_longer_than_1", 32'(long_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
